// File: rtl/s2mm_bank_writer_pkg.sv
// Shared definitions for the stream-to-bank matrix writer: FSM encoding,
// stream geometry and default sizing.
package s2mm_bank_writer_pkg;

    localparam int AXIS_W           = 32;
    localparam int KEEP_W           = AXIS_W / 8;
    localparam int D_W_DEF          = 32;
    localparam int N1_DEF           = 4;
    localparam int MATRIXSIZE_W_DEF = 16;
    localparam int ADDR_W_DEF       = 12;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RECV = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bank index width, kept at least one bit so a single-bank build still elaborates.
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s2mm_bank_writer_addr_gen.sv
// Row-interleaved address walker: column within a row, bank (row mod N1),
// row block and the running block base address.
module s2mm_addr_gen
    import s2mm_bank_writer_pkg::*;
#(
    parameter int N1           = N1_DEF,
    parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int BANK_W       = bank_w(N1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    advance,
    input  logic [MATRIXSIZE_W-1:0] m3,
    input  logic [MATRIXSIZE_W-1:0] m1dn1,
    output logic [BANK_W-1:0]       bank,
    output logic [ADDR_W-1:0]       addr,
    output logic                    is_final
);

    logic [MATRIXSIZE_W-1:0] col;
    logic [MATRIXSIZE_W-1:0] blk;
    logic [BANK_W-1:0]       bank_q;
    logic [ADDR_W-1:0]       base;

    logic col_last;
    logic bank_last;
    logic blk_last;

    assign col_last  = (col == m3 - MATRIXSIZE_W'(1));
    assign bank_last = (bank_q == BANK_W'(N1 - 1));
    assign blk_last  = (blk == m1dn1 - MATRIXSIZE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            blk    <= '0;
            bank_q <= '0;
            base   <= '0;
        end else if (clear) begin
            col    <= '0;
            blk    <= '0;
            bank_q <= '0;
            base   <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                if (bank_last) begin
                    // Every bank has received this block's row; step to the next block.
                    bank_q <= '0;
                    blk    <= blk + MATRIXSIZE_W'(1);
                    base   <= base + ADDR_W'(m3);
                end else begin
                    bank_q <= bank_q + BANK_W'(1);
                end
            end else begin
                col <= col + MATRIXSIZE_W'(1);
            end
        end
    end

    assign bank     = bank_q;
    assign addr     = base + ADDR_W'(col);
    assign is_final = col_last && bank_last && blk_last;

endmodule

// File: rtl/s2mm_bank_writer.sv
// AXI-Stream slave that scatters a matrix row-interleaved across N1 write-port
// banks, with a one-cycle registered write stage and a load_done pulse.
module s2mm_bank_writer
    import s2mm_bank_writer_pkg::*;
#(
    parameter int D_W          = D_W_DEF,
    parameter int N1           = N1_DEF,
    parameter int MATRIXSIZE_W = MATRIXSIZE_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] M3,
    input  logic [MATRIXSIZE_W-1:0] M1dN1,
    input  logic [AXIS_W-1:0]       s_axis_s2mm_tdata,
    input  logic [KEEP_W-1:0]       s_axis_s2mm_tkeep,
    input  logic                    s_axis_s2mm_tlast,
    input  logic                    s_axis_s2mm_tvalid,
    output logic                    s_axis_s2mm_tready,
    output logic [N1-1:0]           wr_en,
    output logic [N1*ADDR_W-1:0]    wr_addr,
    output logic [N1*D_W-1:0]       wr_data,
    output logic                    busy,
    output logic                    load_done,
    output logic                    err
);

    localparam int BANK_W = bank_w(N1);

    state_t                  state;
    logic [MATRIXSIZE_W-1:0] m3_q;
    logic [MATRIXSIZE_W-1:0] m1dn1_q;
    logic                    err_q;

    logic                    start_go;
    logic                    accept;
    logic                    beat_bad;
    logic [BANK_W-1:0]       gen_bank;
    logic [ADDR_W-1:0]       gen_addr;
    logic                    gen_final;

    logic [N1-1:0]           wr_en_p1;
    logic [ADDR_W-1:0]       addr_p1 [N1];
    logic [D_W-1:0]          data_p1 [N1];

    assign start_go = (state == ST_IDLE) && start;
    assign accept   = s_axis_s2mm_tvalid && (state == ST_RECV);
    assign beat_bad = (s_axis_s2mm_tlast != gen_final) ||
                      (s_axis_s2mm_tkeep != {KEEP_W{1'b1}});

    s2mm_addr_gen #(
        .N1           (N1),
        .MATRIXSIZE_W (MATRIXSIZE_W),
        .ADDR_W       (ADDR_W),
        .BANK_W       (BANK_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_go),
        .advance  (accept),
        .m3       (m3_q),
        .m1dn1    (m1dn1_q),
        .bank     (gen_bank),
        .addr     (gen_addr),
        .is_final (gen_final)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            m3_q    <= '0;
            m1dn1_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m3_q    <= M3;
                        m1dn1_q <= M1dN1;
                        err_q   <= 1'b0;
                        // An empty matrix completes without accepting anything.
                        if (M3 == '0 || M1dN1 == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (accept) begin
                        if (beat_bad) begin
                            err_q <= 1'b1;
                        end
                        if (gen_final) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write stage: one cycle after accept, only the target bank is updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_p1 <= '0;
            for (int b = 0; b < N1; b++) begin
                addr_p1[b] <= '0;
                data_p1[b] <= '0;
            end
        end else begin
            wr_en_p1 <= '0;
            if (accept) begin
                wr_en_p1[gen_bank] <= 1'b1;
                addr_p1[gen_bank]  <= gen_addr;
                data_p1[gen_bank]  <= D_W'(s_axis_s2mm_tdata);
            end
        end
    end

    for (genvar b = 0; b < N1; b++) begin : g_flat
        assign wr_addr[b*ADDR_W +: ADDR_W] = addr_p1[b];
        assign wr_data[b*D_W +: D_W]       = data_p1[b];
    end

    assign wr_en              = wr_en_p1;
    assign s_axis_s2mm_tready = (state == ST_RECV);
    assign busy               = (state != ST_IDLE);
    assign load_done          = (state == ST_DONE);
    assign err                = err_q;

endmodule

// File: tb/tb_s2mm_bank_writer.sv
// Directed bench for s2mm_bank_writer: a matrix-level model checked every cycle
// plus literal expectations on selected beats.
module tb_s2mm_bank_writer;

    localparam int N1 = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [15:0]   M3;
    logic [15:0]   M1dN1;
    logic [31:0]   tdata;
    logic [3:0]    tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [N1-1:0] wr_en;
    logic [N1*AW-1:0] wr_addr;
    logic [N1*DW-1:0] wr_data;
    logic          busy;
    logic          load_done;
    logic          err;

    s2mm_bank_writer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .M3                 (M3),
        .M1dN1              (M1dN1),
        .s_axis_s2mm_tdata  (tdata),
        .s_axis_s2mm_tkeep  (tkeep),
        .s_axis_s2mm_tlast  (tlast),
        .s_axis_s2mm_tvalid (tvalid),
        .s_axis_s2mm_tready (tready),
        .wr_en              (wr_en),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .busy               (busy),
        .load_done          (load_done),
        .err                (err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Matrix-level model: beat k of a transfer lands at row k/M3, column k%M3.
    int          m_st;     // 0 idle, 1 receiving, 2 done
    int          m_cnt, m_total, m_m3;
    bit          m_err;
    logic [3:0]  m_en;
    logic [11:0] m_addr [N1];
    logic [31:0] m_data [N1];
    int          row, col, bk, ad;
    bit          lastbeat;
    logic [N1*AW-1:0] e_addr;
    logic [N1*DW-1:0] e_data;

    // Observation log of DUT writes for the literal checks.
    int          log_n, ld_cnt, cyc, ld_cyc, last_wr_cyc;
    int          lg_bank [64];
    int          lg_addr [64];
    logic [31:0] lg_data [64];

    always @(posedge clk) begin
        cyc++;
        m_en = '0;
        if (!rst_n) begin
            m_st = 0; m_cnt = 0; m_total = 0; m_m3 = 0; m_err = 0;
            for (int b = 0; b < N1; b++) begin
                m_addr[b] = '0;
                m_data[b] = '0;
            end
        end else begin
            case (m_st)
                0: if (start) begin
                    m_m3    = int'(M3);
                    m_total = int'(M3) * int'(M1dN1) * N1;
                    m_cnt   = 0;
                    m_err   = 0;
                    m_st    = (m_total == 0) ? 2 : 1;
                end
                1: if (tvalid) begin
                    row = m_cnt / m_m3;
                    col = m_cnt % m_m3;
                    bk  = row % N1;
                    ad  = (row / N1) * m_m3 + col;
                    m_en[bk]   = 1'b1;
                    m_addr[bk] = 12'(ad);
                    m_data[bk] = tdata;
                    lastbeat = (m_cnt == m_total - 1);
                    if (tlast != lastbeat || tkeep != 4'hF) m_err = 1;
                    m_cnt++;
                    if (lastbeat) m_st = 2;
                end
                default: m_st = 0;
            endcase
        end
        #1;
        for (int b = 0; b < N1; b++) begin
            e_addr[b*AW +: AW] = m_addr[b];
            e_data[b*DW +: DW] = m_data[b];
        end
        check("tready", tready, m_st == 1);
        check("busy", busy, m_st != 0);
        check("load_done", load_done, m_st == 2);
        check("err", err, m_err);
        check("wr_en", wr_en, m_en);
        check("wr_addr", wr_addr, e_addr);
        check("wr_data", wr_data, e_data);
        if (wr_en != '0 && log_n < 64) begin
            for (int b = 0; b < N1; b++) begin
                if (wr_en[b]) begin
                    lg_bank[log_n] = b;
                    lg_addr[log_n] = int'(wr_addr[b*AW +: AW]);
                    lg_data[log_n] = wr_data[b*DW +: DW];
                end
            end
            log_n++;
            last_wr_cyc = cyc;
        end
        if (load_done) begin
            ld_cnt++;
            ld_cyc = cyc;
        end
    end

    task automatic clear_logs();
        log_n = 0; ld_cnt = 0; ld_cyc = -1; last_wr_cyc = -2;
    endtask

    task automatic start_xfer(input logic [15:0] m3v, input logic [15:0] m1v);
        @(negedge clk);
        M3 = m3v; M1dN1 = m1v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input bit last, input logic [3:0] keep);
        int k;
        @(negedge clk);
        tvalid = 1'b1; tdata = d; tlast = last; tkeep = keep;
        k = 0;
        while (!tready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: beat %0h never accepted", d);
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0; tkeep = 4'hF;
    endtask

    task automatic run_matrix(input int dbase, input bit gaps, input int last_a,
                              input int last_b, input int keep_idx);
        for (int i = 0; i < 24; i++) begin
            if (gaps && i == 12) begin
                bus_idle();
                repeat (9) @(negedge clk);
            end else if (gaps && (i % 2 == 1)) begin
                bus_idle();
            end
            send_beat(32'(dbase + i), (i == last_a) || (i == last_b),
                      (i == keep_idx) ? 4'h7 : 4'hF);
        end
        bus_idle();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 40) begin
            n_fail++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, k);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, busy=%0d", busy);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; M3 = 16'd3; M1dN1 = 16'd2;
        tdata = '0; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b0;
        clear_logs();
        #2;
        check("rst_tready", tready, 1'b0);
        check("rst_wr_en", wr_en, 4'h0);
        check("rst_load_done", load_done, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back full matrix
        clear_logs();
        start_xfer(16'd3, 16'd2);
        run_matrix(0, 1'b0, 23, -1, -1);
        wait_idle();
        check("t1_count", log_n, 24);
        check("t1_b5_bank", lg_bank[5], 1);
        check("t1_b5_addr", lg_addr[5], 2);
        check("t1_b13_bank", lg_bank[13], 0);
        check("t1_b13_addr", lg_addr[13], 4);
        check("t1_b23_bank", lg_bank[23], 3);
        check("t1_b23_addr", lg_addr[23], 5);
        check("t1_b23_data", lg_data[23], 32'd23);
        check("t1_ld_cnt", ld_cnt, 1);
        check("t1_ld_with_last_write", ld_cyc, last_wr_cyc);
        check("t1_err", err, 1'b0);

        // Early tlast on beat 7
        clear_logs();
        start_xfer(16'd3, 16'd2);
        run_matrix(200, 1'b0, 23, 7, -1);
        wait_idle();
        check("t3_err", err, 1'b1);
        check("t3_ld_cnt", ld_cnt, 1);
        check("t3_count", log_n, 24);
        check("t3_tready_after", tready, 1'b0);
        @(negedge clk);
        tvalid = 1'b1; tdata = 32'hDEAD;
        repeat (3) @(negedge clk);
        tvalid = 1'b0;
        check("t3_no_extra_writes", log_n, 24);

        // Missing tlast on the final beat
        clear_logs();
        start_xfer(16'd3, 16'd2);
        check("t4_err_cleared", err, 1'b0);
        run_matrix(300, 1'b0, -1, -1, -1);
        wait_idle();
        check("t4_err", err, 1'b1);
        check("t4_ld_cnt", ld_cnt, 1);

        // tvalid toggling plus a long gap
        clear_logs();
        start_xfer(16'd3, 16'd2);
        run_matrix(100, 1'b1, 23, -1, -1);
        wait_idle();
        check("t2_count", log_n, 24);
        check("t2_b5_bank", lg_bank[5], 1);
        check("t2_b5_addr", lg_addr[5], 2);
        check("t2_b5_data", lg_data[5], 32'd105);
        check("t2_b13_addr", lg_addr[13], 4);
        check("t2_b23_bank", lg_bank[23], 3);
        check("t2_ld_cnt", ld_cnt, 1);
        check("t2_err", err, 1'b0);

        // Partial tkeep on beat 2
        clear_logs();
        start_xfer(16'd3, 16'd2);
        run_matrix(400, 1'b0, 23, -1, 2);
        wait_idle();
        check("t5_err", err, 1'b1);

        // Empty matrix
        clear_logs();
        start_xfer(16'd0, 16'd2);
        repeat (4) @(negedge clk);
        check("t6_ld_cnt", ld_cnt, 1);
        check("t6_no_writes", log_n, 0);
        check("t6_busy", busy, 1'b0);

        // Reset in the middle of a transfer
        clear_logs();
        start_xfer(16'd3, 16'd2);
        for (int i = 0; i <= 10; i++) send_beat(32'(500 + i), 1'b0, 4'hF);
        bus_idle();
        rst_n = 1'b0;
        #1;
        check("t7_rst_wr_en", wr_en, 4'h0);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_tready", tready, 1'b0);
        check("t7_rst_wr_addr", wr_addr, '0);
        check("t7_rst_wr_data", wr_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        check("t7_no_ld", ld_cnt, 0);
        clear_logs();
        start_xfer(16'd3, 16'd2);
        run_matrix(600, 1'b0, 23, -1, -1);
        wait_idle();
        check("t7_count", log_n, 24);
        check("t7_b0_bank", lg_bank[0], 0);
        check("t7_b0_addr", lg_addr[0], 0);
        check("t7_b0_data", lg_data[0], 32'd600);
        check("t7_ld_cnt", ld_cnt, 1);

        // start held and M3 changed during the transfer
        clear_logs();
        @(negedge clk);
        M3 = 16'd3; M1dN1 = 16'd2; start = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 8) M3 = 16'd5;
            if (i == 15) begin
                start = 1'b0;
                M3 = 16'd3;
            end
            send_beat(32'(700 + i), i == 23, 4'hF);
        end
        bus_idle();
        wait_idle();
        repeat (3) @(negedge clk);
        check("t8_count", log_n, 24);
        check("t8_b13_bank", lg_bank[13], 0);
        check("t8_b13_addr", lg_addr[13], 4);
        check("t8_b23_addr", lg_addr[23], 5);
        check("t8_ld_cnt", ld_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
